// File: rtl/div16_pkg.sv
// Shared types and constants for the 16-bit sequential divider.
// Optional divide-by-zero early exit: DIV16_ZERO_DETECT_EN.
package div16_pkg;

  localparam int N     = 16;
  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/div16_seq_sub.sv
// a16bitsub: 16-bit ripple-borrow subtractor, diff = a - b - bin.
// Borrow ripples LSB to MSB through one full subtractor per bit.
module a16bitsub
  import div16_pkg::*;
(
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i]  = a[i] ^ b[i] ^ brw[i];
    assign brw[i+1] = (~a[i] & (b[i] | brw[i]))
                    | (b[i] & brw[i]);
  end

  assign bout = brw[N];

endmodule

// File: rtl/div16_seq.sv
// div16_seq: restoring unsigned divider, one quotient bit per clock.
// Optional divide-by-zero early exit: DIV16_ZERO_DETECT_EN.
module div16_seq #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dz
);

  import div16_pkg::*;

  if (N != div16_pkg::N) begin : g_bad_n
    $error("div16_seq: N must be 16");
  end

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     r_q, r_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     d_q, d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     rem_q, rem_d;

  logic         msb;
  logic [N-1:0] t;
  logic [N-1:0] sub;
  logic         bo;
  logic         qbit;
  logic [N-1:0] r_nxt;
  logic [N-1:0] q_nxt;

  // One restoring step: shift in the next dividend bit, try T - D.
  // With msb set the true 17-bit remainder exceeds D, so sub is valid.
  assign msb   = r_q[N-1];
  assign t     = {r_q[N-2:0], q_q[N-1]};
  assign qbit  = msb | ~bo;
  assign r_nxt = qbit ? sub : t;
  assign q_nxt = {q_q[N-2:0], qbit};

  a16bitsub u_sub (
    .a    (t),
    .b    (d_q),
    .bin  (1'b0),
    .diff (sub),
    .bout (bo)
  );

`ifdef DIV16_ZERO_DETECT_EN
  logic dz_q, dz_d;
  assign dz = dz_q;
`else
  assign dz = 1'b0;
`endif

  // Next-state: FSM, iteration counter, R/Q/D and result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV16_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
`ifdef DIV16_ZERO_DETECT_EN
          if (divisor == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            quo_d   = '1;
            rem_d   = dividend;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d   = r_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = q_nxt;
          rem_d   = r_nxt;
`ifdef DIV16_ZERO_DETECT_EN
          dz_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any divide in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV16_ZERO_DETECT_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV16_ZERO_DETECT_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div16_seq.sv
// Testbench for div16_seq against an arithmetic reference model.
// Build with DIV16_ZERO_DETECT_EN to exercise the early-exit path.
module tb_div16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        dz;

  int n_checks = 0;
  int n_fail = 0;

`ifdef DIV16_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  always #5 clk = ~clk;

  div16_seq #(.N(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  // Reference: plain integer division; x/0 gives all-ones, rem x.
  function automatic void ref_div(
    input  logic [15:0] a, b,
    output logic [15:0] q, r);
    if (b == 16'd0) begin
      q = 16'hFFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Edges counted from the accepting edge through the done edge.
  function automatic int ref_lat(input logic [15:0] b);
    return (ZD && b == 16'd0) ? 1 : 17;
  endfunction

  function automatic int ref_busy(input logic [15:0] b);
    return (ZD && b == 16'd0) ? 0 : 16;
  endfunction

  // Present operands with start, then count edges until done.
  // A nonzero glitch drives a stray start at that sample.
  task automatic run_div(
    input  logic [15:0] a, b,
    input  int          glitch,
    output int          lat,
    output int          bsy,
    output bit          tmo);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat = 0;
    bsy = 0;
    tmo = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      start    = (lat == glitch);
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      if (busy) bsy++;
      if (done) break;
      if (lat > 40) begin
        tmo = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({busy, done, dz, quotient, remainder} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outs got %h want 0",
        {busy, done, dz, quotient, remainder});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_flags got %b want 00", {busy, done});
    end
  endtask

  task automatic test_basic();
    int lat, bsy;
    bit tmo;
    @(negedge clk);
    run_div(16'd100, 16'd7, 0, lat, bsy, tmo);
    n_checks++;
    if (tmo !== 1'b0 || lat != 17) begin
      n_fail++;
      $display("FAIL basic_lat got %0d want 17", lat);
    end
    n_checks++;
    if (bsy != 16) begin
      n_fail++;
      $display("FAIL basic_busy got %0d want 16", bsy);
    end
    n_checks++;
    if (quotient !== 16'd14 || remainder !== 16'd2 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_res got %0d r %0d dz %b want 14 r 2 dz 0",
        quotient, remainder, dz);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || quotient !== 16'd14) begin
      n_fail++;
      $display("FAIL basic_pulse got done %b q %0d want 0 q 14",
        done, quotient);
    end
  endtask

  task automatic test_msb();
    int lat, bsy;
    bit tmo;
    @(negedge clk);
    run_div(16'hFFFF, 16'h8001, 0, lat, bsy, tmo);
    n_checks++;
    if (tmo || quotient !== 16'h0001 || remainder !== 16'h7FFE) begin
      n_fail++;
      $display("FAIL msb_res got %h r %h want 0001 r 7ffe",
        quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bsy;
    bit tmo;
    @(negedge clk);
    run_div(16'hFFFF, 16'd1, 0, lat, bsy, tmo);
    n_checks++;
    if (tmo || quotient !== 16'hFFFF || remainder !== 16'h0000) begin
      n_fail++;
      $display("FAIL b2b_first got %h r %h want ffff r 0000",
        quotient, remainder);
    end
    run_div(16'd5, 16'd9, 0, lat, bsy, tmo);
    n_checks++;
    if (tmo || lat != 17 || bsy != 16) begin
      n_fail++;
      $display("FAIL b2b_lat got lat %0d busy %0d want 17 16",
        lat, bsy);
    end
    n_checks++;
    if (quotient !== 16'd0 || remainder !== 16'd5) begin
      n_fail++;
      $display("FAIL b2b_res got %0d r %0d want 0 r 5",
        quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int lat, bsy;
    bit tmo;
    @(negedge clk);
    run_div(16'd1234, 16'd0, 0, lat, bsy, tmo);
    n_checks++;
    if (tmo || lat != ref_lat(16'd0) || bsy != ref_busy(16'd0)) begin
      n_fail++;
      $display("FAIL dz_lat got lat %0d busy %0d want %0d %0d",
        lat, bsy, ref_lat(16'd0), ref_busy(16'd0));
    end
    n_checks++;
    if (quotient !== 16'hFFFF || remainder !== 16'd1234 || dz !== ZD) begin
      n_fail++;
      $display("FAIL dz_res got %h r %0d dz %b want ffff r 1234 dz %b",
        quotient, remainder, dz, ZD);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bsy;
    bit tmo;
    logic [15:0] eq, er;
    ref_div(16'd1000, 16'd13, eq, er);
    @(negedge clk);
    run_div(16'd1000, 16'd13, 5, lat, bsy, tmo);
    n_checks++;
    if (tmo || lat != 17 || quotient !== eq || remainder !== er) begin
      n_fail++;
      $display("FAIL ignore got %0d r %0d lat %0d want %0d r %0d lat 17",
        quotient, remainder, lat, eq, er);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_busy got %b want 0", busy);
    end
  endtask

  task automatic test_abort();
    int lat, bsy;
    bit tmo;
    bit seen;
    @(negedge clk);
    dividend = 16'd300;
    divisor  = 16'd11;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, dz, quotient, remainder} !== 35'd0) begin
      n_fail++;
      $display("FAIL abort_outs got %h want 0",
        {busy, done, dz, quotient, remainder});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_nodone got %b want 0", seen);
    end
    @(negedge clk);
    run_div(16'd100, 16'd7, 0, lat, bsy, tmo);
    n_checks++;
    if (tmo || lat != 17 || quotient !== 16'd14 || remainder !== 16'd2) begin
      n_fail++;
      $display("FAIL abort_rerun got %0d r %0d lat %0d want 14 r 2 lat 17",
        quotient, remainder, lat);
    end
  endtask

  task automatic test_random();
    int lat, bsy;
    bit tmo;
    logic [15:0] a, b, eq, er;
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom);
      case (k % 4)
        0: b = 16'($urandom);
        1: b = 16'($urandom_range(1, 40));
        2: b = 16'($urandom) | 16'h8000;
        default: b = (k == 3) ? 16'd0 : 16'($urandom_range(0, 3));
      endcase
      ref_div(a, b, eq, er);
      if (k % 2 == 0) @(negedge clk);
      run_div(a, b, int'($urandom_range(0, 15)), lat, bsy, tmo);
      n_checks++;
      if (tmo || lat != ref_lat(b) || quotient !== eq ||
          remainder !== er || dz !== (ZD && b == 16'd0)) begin
        n_fail++;
        $display("FAIL rand %h/%h got %h r %h dz %b lat %0d want %h r %h lat %0d",
          a, b, quotient, remainder, dz, lat, eq, er, ref_lat(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
